// File: rtl/irq_controller_if.sv
// Bundle of interrupt lines, controller handshake and status between irq_controller and the CPU control unit.
// The controller side uses the slave modport; the CPU/environment side uses master.
interface irq_controller_if #(
  parameter int N_SRC = 4,
  parameter int ID_W  = $clog2(N_SRC)
);
  logic [N_SRC-1:0] irq_src;
  logic [N_SRC-1:0] irq_mask;
  logic             ExtIAck;
  logic             ERet;
  logic             ExtIRQ;
  logic [ID_W-1:0]  IrqId;
  logic [N_SRC-1:0] IrqPending;
  logic             InService;

  modport master (
    output irq_src, irq_mask, ExtIAck, ERet,
    input  ExtIRQ, IrqId, IrqPending, InService
  );

  modport slave (
    input  irq_src, irq_mask, ExtIAck, ERet,
    output ExtIRQ, IrqId, IrqPending, InService
  );
endinterface

// File: rtl/irq_controller.sv
// External interrupt front-end: synchronize, latch pending, mask, prioritize, and hand one request to the CPU.
// Define IRQ_LEVEL_EN for level-sensitive pending bits instead of rising-edge latching.
module irq_controller #(
  parameter int N_SRC       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int ID_W        = $clog2(N_SRC)
) (
  input  logic clk,
  input  logic reset,
  irq_controller_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t           state;
  state_t           state_next;
  logic [N_SRC-1:0] sync_q [SYNC_STAGES];
  logic [N_SRC-1:0] sync_last;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] eligible;
  logic [ID_W-1:0]  irq_id;
  logic [ID_W-1:0]  lowest_id;
  logic             ext_irq;
  logic             in_service;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= bus.irq_src;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign sync_last = sync_q[SYNC_STAGES-1];

`ifdef IRQ_LEVEL_EN
  assign pending = sync_last;
`else
  logic [N_SRC-1:0]   sync_prev;
  logic [N_SRC-1:0]   edge_det;
  logic [N_SRC-1:0]   ack_clr;
  logic [SYNC_STAGES:0] warm;

  // Edges stay masked until the synchronizer and sync_prev hold real line levels,
  // so a line already high when reset releases is not mistaken for a new edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_prev <= '0;
      warm      <= '0;
      pending   <= '0;
    end else begin
      sync_prev <= sync_last;
      warm      <= {warm[SYNC_STAGES-1:0], 1'b1};
      pending   <= (pending & ~ack_clr) | edge_det;
    end
  end

  assign edge_det = warm[SYNC_STAGES] ? (sync_last & ~sync_prev) : '0;
  assign ack_clr  = (state == REQ && bus.ExtIAck) ? (N_SRC'(1) << irq_id) : '0;
`endif

  assign eligible = pending & bus.irq_mask;

  always_comb begin
    lowest_id = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) lowest_id = ID_W'(i);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      irq_id <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && |eligible) irq_id <= lowest_id;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (|eligible)    state_next = REQ;
      REQ:     if (bus.ExtIAck)  state_next = SERVICE;
      SERVICE: if (bus.ERet)     state_next = IDLE;
      default:                   state_next = IDLE;
    endcase
  end

  always_comb begin
    ext_irq    = 1'b0;
    in_service = 1'b0;
    case (state)
      REQ:     ext_irq    = 1'b1;
      SERVICE: in_service = 1'b1;
      default: ;
    endcase
  end

  assign bus.ExtIRQ     = ext_irq;
  assign bus.InService  = in_service;
  assign bus.IrqId      = irq_id;
  assign bus.IrqPending = pending;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: edge-latched mode by default, level mode when IRQ_LEVEL_EN is defined.
module tb_irq_controller;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  irq_controller_if #(.N_SRC(4)) bus ();

  irq_controller #(.N_SRC(4), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic ack, input logic eret);
    bus.ExtIAck = ack;
    bus.ERet    = eret;
    tick(1);
    bus.ExtIAck = 1'b0;
    bus.ERet    = 1'b0;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    reset       = 1'b1;
    bus.irq_src = 4'b0000;
    bus.irq_mask = 4'b0000;
    bus.ExtIAck = 1'b0;
    bus.ERet    = 1'b0;
    #2 reset = 1'b0;
    #1;
    checkOutput("rst_extirq",  bus.ExtIRQ, 0);
    checkOutput("rst_id",      bus.IrqId, 0);
    checkOutput("rst_pending", bus.IrqPending, 0);
    checkOutput("rst_insvc",   bus.InService, 0);
    tick(2);
    reset = 1'b1;
    tick(5);
    bus.irq_mask = 4'b1111;

`ifndef IRQ_LEVEL_EN
    // Single edge on source 2: request appears after the fourth edge.
    bus.irq_src = 4'b0100;
    tick(3);
    checkOutput("single_noreq_e3", bus.ExtIRQ, 0);
    checkOutput("single_pend_e3",  bus.IrqPending, 4'b0100);
    bus.irq_src = 4'b0000;
    tick(1);
    checkOutput("single_req_e4", bus.ExtIRQ, 1);
    checkOutput("single_id",     bus.IrqId, 2);
    applyStimulus(1'b1, 1'b0);
    checkOutput("single_ack_irq",   bus.ExtIRQ, 0);
    checkOutput("single_ack_svc",   bus.InService, 1);
    checkOutput("single_ack_pend",  bus.IrqPending, 0);
    tick(2);
    checkOutput("single_svc_hold", bus.InService, 1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("single_eret_svc", bus.InService, 0);
    checkOutput("single_eret_irq", bus.ExtIRQ, 0);
    tick(3);

    // Source 3 wins first; a later source 1 must not disturb the frozen id.
    bus.irq_src = 4'b1000;
    tick(1);
    bus.irq_src = 4'b1010;
    tick(3);
    checkOutput("prio_req",     bus.ExtIRQ, 1);
    checkOutput("prio_id3",     bus.IrqId, 3);
    tick(1);
    checkOutput("prio_pend",    bus.IrqPending, 4'b1010);
    checkOutput("prio_frozen",  bus.IrqId, 3);
    bus.irq_src = 4'b0000;
    applyStimulus(1'b1, 1'b0);
    checkOutput("prio_ack_pend", bus.IrqPending, 4'b0010);
    checkOutput("prio_ack_svc",  bus.InService, 1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("prio_idle_gap", bus.ExtIRQ, 0);
    tick(1);
    checkOutput("prio_next_req", bus.ExtIRQ, 1);
    checkOutput("prio_next_id",  bus.IrqId, 1);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1);
    tick(3);
    checkOutput("prio_clean", bus.IrqPending, 0);

    // Masked source stays pending until enabled; masking later does not withdraw.
    bus.irq_mask = 4'b1110;
    bus.irq_src  = 4'b0001;
    tick(3);
    bus.irq_src  = 4'b0000;
    tick(3);
    checkOutput("mask_noreq", bus.ExtIRQ, 0);
    checkOutput("mask_pend",  bus.IrqPending, 4'b0001);
    bus.irq_mask = 4'b1111;
    tick(1);
    checkOutput("mask_req", bus.ExtIRQ, 1);
    checkOutput("mask_id",  bus.IrqId, 0);
    bus.irq_mask = 4'b0000;
    tick(2);
    checkOutput("mask_nowithdraw", bus.ExtIRQ, 1);
    bus.irq_mask = 4'b1111;
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1);
    tick(3);

    // Source 2 re-edges exactly on the ack edge: the set must win.
    bus.irq_src = 4'b0100;
    tick(2);
    bus.irq_src = 4'b0000;
    tick(2);
    checkOutput("coll_req", bus.ExtIRQ, 1);
    checkOutput("coll_id",  bus.IrqId, 2);
    bus.irq_src = 4'b0100;
    tick(2);
    applyStimulus(1'b1, 1'b0);
    checkOutput("coll_svc",  bus.InService, 1);
    checkOutput("coll_pend", bus.IrqPending, 4'b0100);
    applyStimulus(1'b0, 1'b1);
    checkOutput("coll_idle", bus.ExtIRQ, 0);
    tick(1);
    checkOutput("coll_rereq", bus.ExtIRQ, 1);
    checkOutput("coll_reid",  bus.IrqId, 2);
    bus.irq_src = 4'b0000;
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1);
    tick(3);

    // Asynchronous reset in SERVICE with sources still high afterwards.
    bus.irq_src = 4'b1011;
    tick(4);
    checkOutput("rsvc_req", bus.ExtIRQ, 1);
    applyStimulus(1'b1, 1'b0);
    checkOutput("rsvc_pend", bus.IrqPending, 4'b1010);
    checkOutput("rsvc_svc",  bus.InService, 1);
    #2 reset = 1'b0;
    #1;
    checkOutput("rsvc_async_irq",  bus.ExtIRQ, 0);
    checkOutput("rsvc_async_svc",  bus.InService, 0);
    checkOutput("rsvc_async_pend", bus.IrqPending, 0);
    checkOutput("rsvc_async_id",   bus.IrqId, 0);
    #2 reset = 1'b1;
    tick(8);
    checkOutput("rsvc_noreq",   bus.ExtIRQ, 0);
    checkOutput("rsvc_nopend",  bus.IrqPending, 0);
    bus.irq_src = 4'b0000;
    tick(4);
    checkOutput("rsvc_quiet", bus.IrqPending, 0);
`else
    // Level mode: a held source is re-requested right after ERet.
    bus.irq_src = 4'b0010;
    tick(2);
    checkOutput("lvl_pend",  bus.IrqPending, 4'b0010);
    checkOutput("lvl_noreq", bus.ExtIRQ, 0);
    tick(1);
    checkOutput("lvl_req", bus.ExtIRQ, 1);
    checkOutput("lvl_id",  bus.IrqId, 1);
    applyStimulus(1'b1, 1'b0);
    checkOutput("lvl_svc",      bus.InService, 1);
    checkOutput("lvl_ack_pend", bus.IrqPending, 4'b0010);
    applyStimulus(1'b0, 1'b1);
    checkOutput("lvl_idle", bus.ExtIRQ, 0);
    tick(1);
    checkOutput("lvl_rereq", bus.ExtIRQ, 1);
    applyStimulus(1'b1, 1'b0);
    bus.irq_src = 4'b0000;
    tick(3);
    checkOutput("lvl_drop_pend", bus.IrqPending, 0);
    applyStimulus(1'b0, 1'b1);
    tick(2);
    checkOutput("lvl_stay_idle", bus.ExtIRQ, 0);
    checkOutput("lvl_stay_svc",  bus.InService, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
